gin_multicast_bus: RTL and testbench
====================================

# gin_multicast_bus

Global Input Network (GIN) delivery fabric that sits between the top-level controller's IFMAP/FILTER/IPSUM send ports and the PE array. It accepts one tagged word per handshake (row tag, column tag, data), matches the tags against per-row and per-PE ID registers loaded over the scan chain, and multicasts the word to every matching PE under a per-PE enable/ready handshake. One instance is used per GIN: IFMAP, FILTER and IPSUM.

## Interface
- NUM_ROWS, 4, PE array rows (X-buses)
- NUM_COLS, 4, PEs per row
- ID_LEN, 4, bit width of row/column IDs and tags
- DATA_BITWIDTH, 32, payload width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- set_info  in  1  scan-chain shift enable
- scan_id  in  ID_LEN  scan-chain ID word, shifted in when set_info=1
- in_row_id  in  ID_LEN  row tag of the offered word
- in_col_id  in  ID_LEN  column tag of the offered word
- in_data  in  DATA_BITWIDTH  payload
- in_enable  in  1  source valid
- in_ready  out  1  fabric can accept
- pe_enable  out  NUM_ROWS*NUM_COLS  per-PE valid; bit index r*NUM_COLS+c
- pe_data  out  DATA_BITWIDTH  payload broadcast to all PEs
- pe_ready  in  NUM_ROWS*NUM_COLS  per-PE ready
- busy  out  1  a word is held and not yet delivered
- miss  out  1  one-cycle pulse: a held word matched no PE and was dropped

## Operation
- State: row_id[0..R-1], col_id[0..N-1] (N=R*C), hold register {hold_valid, hold_row, hold_col, hold_data}, miss register.
- Scan chain: while set_info=1, every cycle shifts the concatenation {row_id[0..R-1], col_id[0..N-1]} one entry toward lower index; scan_id enters col_id[N-1]; col_id[0] moves to row_id[R-1]; row_id[0] is discarded. After R+N shift cycles the words sent in order are row_id[0]..row_id[R-1], col_id[0]..col_id[N-1].
- ID value all-ones is reserved as "disabled": a register holding all-ones never matches, and a tag of all-ones never matches.
- target[r*C+c] = hold_valid & (row_id[r]==hold_row) & (col_id[r*C+c]==hold_col), with the disabled rule applied.
- fire = hold_valid & ((target & ~pe_ready)==0): delivery is atomic; all targets must be ready in the same cycle.
- pe_enable = target when fire, else 0. pe_data = hold_data always.
- in_ready = ~set_info & (~hold_valid | fire). Accept = in_enable & in_ready; on accept the hold register loads the input and hold_valid=1. Otherwise, if fire, hold_valid clears.
- target==0 with hold_valid=1 fires immediately (drop). miss is registered to 1 for the following cycle, else 0.
- busy = hold_valid.
- The controller asserts set_info only when busy=0. If set_info rises with busy=1, the held word still fires against the IDs present in each cycle. No new word is accepted while set_info=1.

## Timing
- Reset (rst=0, asynchronous): hold_valid=0, hold tags/data=0, all ID registers all-ones, miss=0. As a result pe_enable=0, busy=0, and in_ready=~set_info.
- Latency: a word accepted at edge k is presented on pe_enable during the cycle after edge k. It is delivered at that cycle's edge if all targets are ready.
- Throughput: 1 word/cycle when targets stay ready (accept and fire on the same edge).
- pe_enable depends combinationally on pe_ready. PEs must not derive pe_ready from pe_enable.
- in_ready depends combinationally on pe_ready through fire. No combinational path from in_enable to in_ready.
- Backpressure: the held word and its pe_enable stay 0 until the cycle in which all targets are ready. Inputs are held stable by the source while in_ready=0.
- miss is high exactly one cycle, in the cycle after the dropping edge.
- Reset asserted mid-delivery discards the held word immediately. No pe_enable is produced after rst falls.

## Test plan
- Reset: with rst=0, in_enable=1 and set_info=0 -> pe_enable=0, busy=0, miss=0, in_ready=1. Any word then sent before scan load is dropped with a miss pulse.
- Scan load plus unicast (4x4, ID_LEN=4): shift rows 0,1,2,3, then col IDs 0..3 per row, in 20 set_info cycles. Send tag (2,1), data 0xDEADBEEF, all pe_ready=1 -> pe_enable=0x0200 one cycle after accept, pe_data=0xDEADBEEF.
- Row multicast: load all four row IDs to 5 and all col IDs of row 3 to 7, others to 15. Send tag (5,7) -> pe_enable=0xF000 for a single cycle.
- Atomic backpressure: same setup with pe_ready bit 13 held 0 for 3 cycles -> pe_enable=0, in_ready=0 and busy=1 for 3 cycles, then 0xF000 for one cycle. Next word accepted on that same edge.
- Miss: send tag (9,9), which matches nothing -> no pe_enable, miss=1 for exactly one cycle, in_ready stays 1. Also send tag (15,15) after loading all IDs to 15 -> miss.
- Streaming plus reset: 8 back-to-back words with all ready -> 8 consecutive single-cycle pe_enable pulses. Assert rst during the 4th word with some pe_ready=0 -> busy=0 and pe_enable=0 immediately, and IDs return to all-ones.

Source files
------------

// File: rtl/gin_multicast_bus_if.sv
// gin_multicast_bus_if: source-side tagged-word handshake, scan load and PE-side enable/ready bus
interface gin_multicast_bus_if #(
  parameter int NUM_ROWS = 4,
  parameter int NUM_COLS = 4,
  parameter int ID_LEN = 4,
  parameter int DATA_BITWIDTH = 32
);
  logic set_info;
  logic [ID_LEN-1:0] scan_id;
  logic [ID_LEN-1:0] in_row_id;
  logic [ID_LEN-1:0] in_col_id;
  logic [DATA_BITWIDTH-1:0] in_data;
  logic in_enable;
  logic in_ready;
  logic [NUM_ROWS*NUM_COLS-1:0] pe_enable;
  logic [DATA_BITWIDTH-1:0] pe_data;
  logic [NUM_ROWS*NUM_COLS-1:0] pe_ready;
  logic busy;
  logic miss;
  modport master (
    output set_info, scan_id, in_row_id, in_col_id, in_data, in_enable, pe_ready,
    input in_ready, pe_enable, pe_data, busy, miss
  );
  modport slave (
    input set_info, scan_id, in_row_id, in_col_id, in_data, in_enable, pe_ready,
    output in_ready, pe_enable, pe_data, busy, miss
  );
endinterface

// File: rtl/gin_multicast_bus.sv
// gin_multicast_bus: holds one tagged word and multicasts it atomically to every PE whose scanned IDs match
module gin_multicast_bus #(
  parameter int NUM_ROWS = 4,
  parameter int NUM_COLS = 4,
  parameter int ID_LEN = 4,
  parameter int DATA_BITWIDTH = 32
) (
  input logic clk,
  input logic rst,
  gin_multicast_bus_if.slave bus
);
  localparam int n = NUM_ROWS * NUM_COLS;
  localparam logic [ID_LEN-1:0] disabled_id = '1;
  logic [ID_LEN-1:0] row_id [NUM_ROWS];
  logic [ID_LEN-1:0] col_id [n];
  logic hold_valid, miss_q, fire, accept;
  logic [ID_LEN-1:0] hold_row, hold_col;
  logic [DATA_BITWIDTH-1:0] hold_data;
  logic [n-1:0] target;
  // an all-ones register never matches; equality then also excludes an all-ones tag
  for (genvar p = 0; p < n; p++) begin : g_match
    assign target[p] = hold_valid && row_id[p / NUM_COLS] == hold_row && col_id[p] == hold_col &&
                       row_id[p / NUM_COLS] != disabled_id && col_id[p] != disabled_id;
  end
  assign fire = hold_valid && (target & ~bus.pe_ready) == '0;
  assign accept = bus.in_enable && bus.in_ready;
  assign bus.in_ready = !bus.set_info && (!hold_valid || fire);
  assign bus.pe_enable = fire ? target : '0;
  assign bus.pe_data = hold_data;
  assign bus.busy = hold_valid;
  assign bus.miss = miss_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ROWS; i++) row_id[i] <= disabled_id;
      for (int i = 0; i < n; i++) col_id[i] <= disabled_id;
      hold_valid <= 1'b0;
      hold_row <= '0;
      hold_col <= '0;
      hold_data <= '0;
      miss_q <= 1'b0;
    end else begin
      if (bus.set_info) begin
        for (int i = 0; i < NUM_ROWS - 1; i++) row_id[i] <= row_id[i + 1];
        row_id[NUM_ROWS - 1] <= col_id[0];
        for (int i = 0; i < n - 1; i++) col_id[i] <= col_id[i + 1];
        col_id[n - 1] <= bus.scan_id;
      end
      miss_q <= fire && target == '0;
      if (accept) begin
        hold_valid <= 1'b1;
        hold_row <= bus.in_row_id;
        hold_col <= bus.in_col_id;
        hold_data <= bus.in_data;
      end else if (fire) hold_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_gin_multicast_bus.sv
// tb_gin_multicast_bus: directed scenarios plus randomized traffic against an ID-table/hold-word reference model
module tb_gin_multicast_bus;
  localparam int R = 4, C = 4, N = 16;
  logic clk = 0, rst = 1;
  int vec = 0, errs = 0;
  gin_multicast_bus_if bus ();
  gin_multicast_bus dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  // model: ids[0..R-1] are row IDs, ids[R+p] is the column ID of PE p
  int ids [R+N];
  bit m_valid, m_miss;
  bit [3:0] m_row, m_col;
  bit [31:0] m_data;

  function automatic bit [N-1:0] exp_target();
    bit [N-1:0] t = '0;
    for (int p = 0; p < N; p++) begin
      int r = p / C;
      if (m_valid && ids[r] == int'(m_row) && ids[R+p] == int'(m_col) && ids[r] != 15 && ids[R+p] != 15) t[p] = 1'b1;
    end
    return t;
  endfunction
  function automatic bit exp_fire();
    return m_valid && ((exp_target() & ~bus.pe_ready) == '0);
  endfunction
  function automatic bit [N-1:0] exp_pe();
    return exp_fire() ? exp_target() : '0;
  endfunction
  function automatic bit exp_ready();
    return !bus.set_info && (!m_valid || exp_fire());
  endfunction
  function automatic int rid();
    int v = int'($urandom_range(0, 3));
    return v == 3 ? 15 : v;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_miss = 0; m_row = 0; m_col = 0; m_data = 0;
    for (int i = 0; i < R + N; i++) ids[i] = 15;
  endtask

  task automatic tick();
    bit [N-1:0] t;
    bit f, acc;
    t = exp_target();
    f = exp_fire();
    acc = bus.in_enable && exp_ready();
    @(posedge clk);
    if (!rst) model_reset();
    else begin
      if (bus.set_info) begin
        for (int i = 0; i < R + N - 1; i++) ids[i] = ids[i+1];
        ids[R+N-1] = int'(bus.scan_id);
      end
      m_miss = f && t == '0;
      if (acc) begin
        m_valid = 1; m_row = bus.in_row_id; m_col = bus.in_col_id; m_data = bus.in_data;
      end else if (f) m_valid = 0;
    end
    #1;
  endtask

  task automatic offer(input logic [3:0] r, input logic [3:0] c, input logic [31:0] d);
    bus.in_row_id = r; bus.in_col_id = c; bus.in_data = d; bus.in_enable = 1;
  endtask

  task automatic load_ids(input int w [R+N]);
    bus.in_enable = 0;
    bus.set_info = 1;
    for (int i = 0; i < R + N; i++) begin
      bus.scan_id = 4'(w[i]);
      #1;
      vec++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL scan_in_ready: got %b want 0", bus.in_ready); end
      tick();
    end
    bus.set_info = 0;
  endtask

  task automatic test_reset();
    bus.set_info = 0; bus.scan_id = 0; bus.pe_ready = '1;
    offer(2, 1, 32'h1234_5678);
    #1 rst = 0;
    model_reset();
    #1;
    vec++; if (bus.pe_enable !== 16'h0) begin errs++; $display("FAIL reset_pe_enable: got %h want 0000", bus.pe_enable); end
    vec++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vec++; if (bus.miss !== 1'b0) begin errs++; $display("FAIL reset_miss: got %b want 0", bus.miss); end
    vec++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    tick(); tick();
    rst = 1;
    tick();
    bus.in_enable = 0;
    #1;
    vec++; if (bus.busy !== 1'b1 || bus.pe_enable !== 16'h0) begin errs++; $display("FAIL reset_unloaded_hold: got busy=%b pe=%h want 1 0000", bus.busy, bus.pe_enable); end
    tick();
    vec++; if (bus.miss !== 1'b1 || bus.busy !== 1'b0) begin errs++; $display("FAIL reset_unloaded_miss: got miss=%b busy=%b want 1 0", bus.miss, bus.busy); end
    tick();
    vec++; if (bus.miss !== 1'b0) begin errs++; $display("FAIL reset_miss_width: got %b want 0", bus.miss); end
  endtask

  task automatic test_unicast();
    int w [R+N];
    for (int i = 0; i < R; i++) w[i] = i;
    for (int p = 0; p < N; p++) w[R+p] = p % C;
    load_ids(w);
    offer(2, 1, 32'hDEAD_BEEF);
    #1;
    vec++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL unicast_in_ready: got %b want 1", bus.in_ready); end
    tick();
    bus.in_enable = 0;
    #1;
    vec++; if (bus.pe_enable !== 16'h0200) begin errs++; $display("FAIL unicast_pe_enable: got %h want 0200", bus.pe_enable); end
    vec++; if (bus.pe_enable !== exp_pe()) begin errs++; $display("FAIL unicast_model: got %h want %h", bus.pe_enable, exp_pe()); end
    vec++; if (bus.pe_data !== 32'hDEAD_BEEF) begin errs++; $display("FAIL unicast_pe_data: got %h want deadbeef", bus.pe_data); end
    tick();
    vec++; if (bus.pe_enable !== 16'h0 || bus.busy !== 1'b0) begin errs++; $display("FAIL unicast_after: got pe=%h busy=%b want 0000 0", bus.pe_enable, bus.busy); end
  endtask

  task automatic test_multicast();
    int w [R+N];
    for (int i = 0; i < R; i++) w[i] = 5;
    for (int p = 0; p < N; p++) w[R+p] = p >= 12 ? 7 : 15;
    load_ids(w);
    offer(5, 7, 32'hA5A5_0001);
    tick();
    bus.in_enable = 0;
    #1;
    vec++; if (bus.pe_enable !== 16'hF000) begin errs++; $display("FAIL multicast_pe_enable: got %h want f000", bus.pe_enable); end
    vec++; if (bus.pe_enable !== exp_pe()) begin errs++; $display("FAIL multicast_model: got %h want %h", bus.pe_enable, exp_pe()); end
    tick();
    vec++; if (bus.pe_enable !== 16'h0) begin errs++; $display("FAIL multicast_single: got %h want 0000", bus.pe_enable); end
  endtask

  task automatic test_backpressure();
    offer(5, 7, 32'h0000_00D1);
    tick();
    offer(5, 7, 32'h0000_00D2);
    bus.pe_ready[13] = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vec++; if (bus.pe_enable !== 16'h0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
        errs++; $display("FAIL bp_stall%0d: got pe=%h rdy=%b busy=%b want 0000 0 1", i, bus.pe_enable, bus.in_ready, bus.busy);
      end
      tick();
    end
    bus.pe_ready = '1;
    #1;
    vec++; if (bus.pe_enable !== 16'hF000 || bus.pe_data !== 32'hD1 || bus.in_ready !== 1'b1) begin
      errs++; $display("FAIL bp_release: got pe=%h data=%h rdy=%b want f000 d1 1", bus.pe_enable, bus.pe_data, bus.in_ready);
    end
    tick();
    bus.in_enable = 0;
    #1;
    vec++; if (bus.pe_enable !== 16'hF000 || bus.pe_data !== 32'hD2) begin errs++; $display("FAIL bp_next: got pe=%h data=%h want f000 d2", bus.pe_enable, bus.pe_data); end
    tick();
    vec++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL bp_idle: got %b want 0", bus.busy); end
  endtask

  task automatic test_miss();
    int w [R+N];
    offer(9, 9, 32'h99);
    tick();
    bus.in_enable = 0;
    #1;
    vec++; if (bus.pe_enable !== 16'h0 || bus.in_ready !== 1'b1 || bus.miss !== 1'b0) begin
      errs++; $display("FAIL miss_drop: got pe=%h rdy=%b miss=%b want 0000 1 0", bus.pe_enable, bus.in_ready, bus.miss);
    end
    tick();
    vec++; if (bus.miss !== 1'b1 || bus.miss !== m_miss) begin errs++; $display("FAIL miss_pulse: got %b want 1", bus.miss); end
    tick();
    vec++; if (bus.miss !== 1'b0) begin errs++; $display("FAIL miss_end: got %b want 0", bus.miss); end
    for (int i = 0; i < R + N; i++) w[i] = 15;
    load_ids(w);
    offer(15, 15, 32'hFF);
    tick();
    bus.in_enable = 0;
    tick();
    vec++; if (bus.miss !== 1'b1) begin errs++; $display("FAIL miss_disabled: got %b want 1", bus.miss); end
    tick();
    vec++; if (bus.miss !== 1'b0) begin errs++; $display("FAIL miss_disabled_end: got %b want 0", bus.miss); end
  endtask

  task automatic test_stream_reset();
    int w [R+N];
    int pulses = 0;
    for (int i = 0; i < R; i++) w[i] = i;
    for (int p = 0; p < N; p++) w[R+p] = p % C;
    load_ids(w);
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) offer(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), $urandom());
      else bus.in_enable = 0;
      #1;
      if (i > 0) begin
        vec++; if (bus.pe_enable !== exp_pe() || $countones(bus.pe_enable) != 1 || bus.pe_data !== m_data) begin
          errs++; $display("FAIL stream_word%0d: got pe=%h data=%h want %h %h", i, bus.pe_enable, bus.pe_data, exp_pe(), m_data);
        end
        if (bus.pe_enable != 0) pulses++;
      end
      tick();
    end
    vec++; if (pulses != 8) begin errs++; $display("FAIL stream_pulses: got %0d want 8", pulses); end
    for (int i = 0; i < 4; i++) begin
      offer(4'(i), 4'(i), 32'hC0 + 32'(i));
      tick();
    end
    bus.in_enable = 0;
    bus.pe_ready[15] = 0;
    #1;
    vec++; if (bus.pe_enable !== 16'h0 || bus.busy !== 1'b1) begin errs++; $display("FAIL rst_prehold: got pe=%h busy=%b want 0000 1", bus.pe_enable, bus.busy); end
    rst = 0;
    #1;
    model_reset();
    vec++; if (bus.busy !== 1'b0 || bus.pe_enable !== 16'h0 || bus.in_ready !== 1'b1) begin
      errs++; $display("FAIL rst_mid: got busy=%b pe=%h rdy=%b want 0 0000 1", bus.busy, bus.pe_enable, bus.in_ready);
    end
    tick();
    rst = 1;
    bus.pe_ready = '1;
    offer(0, 0, 32'hE0);
    tick();
    bus.in_enable = 0;
    #1;
    vec++; if (bus.pe_enable !== 16'h0 || bus.busy !== 1'b1) begin errs++; $display("FAIL rst_ids_cleared: got pe=%h busy=%b want 0000 1", bus.pe_enable, bus.busy); end
    tick();
    vec++; if (bus.miss !== 1'b1) begin errs++; $display("FAIL rst_ids_miss: got %b want 1", bus.miss); end
  endtask

  task automatic test_random();
    int w [R+N];
    bit keep = 0;
    for (int i = 0; i < R + N; i++) w[i] = rid();
    load_ids(w);
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.set_info = !m_valid && $urandom_range(0, 11) == 0;
      bus.scan_id = 4'(rid());
      if (!keep) begin
        bus.in_enable = $urandom_range(0, 1) == 1;
        bus.in_row_id = 4'(rid()); bus.in_col_id = 4'(rid()); bus.in_data = $urandom();
      end
      bus.pe_ready = ~16'($urandom() & $urandom() & $urandom());
      #1;
      vec++; if (bus.pe_enable !== exp_pe() || bus.in_ready !== exp_ready() || bus.busy !== m_valid ||
                 bus.miss !== m_miss || bus.pe_data !== m_data) begin
        errs++; $display("FAIL random_c%0d: got pe=%h rdy=%b busy=%b miss=%b data=%h want %h %b %b %b %h", cyc,
          bus.pe_enable, bus.in_ready, bus.busy, bus.miss, bus.pe_data, exp_pe(), exp_ready(), m_valid, m_miss, m_data);
      end
      keep = bus.in_enable && !exp_ready();
      tick();
    end
    bus.set_info = 0;
    bus.in_enable = 0;
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_multicast();
    test_backpressure();
    test_miss();
    test_stream_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
